main_control_fsm: RTL

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/main_control_fsm.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ctrl_pkg.sv
// Shared control encodings: FSM states, opcodes and ALU operation classes.
// Also used by the ALU control decoder and the datapath.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH      = 3'd0,
      S_DECODE     = 3'd1,
      S_EXECUTE    = 3'd2,
      S_MEM_ACCESS = 3'd3,
      S_WRITEBACK  = 3'd4,
      S_BRANCH     = 3'd5,
      S_JUMP       = 3'd6
   } state_t;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_LW    = 4'b0001;
   localparam logic [3:0] OP_SW    = 4'b0010;
   localparam logic [3:0] OP_BEQ   = 4'b0011;
   localparam logic [3:0] OP_ADDI  = 4'b0100;
   localparam logic [3:0] OP_JMP   = 4'b0101;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;
   localparam logic [1:0] ALU_ADDI = 2'b11;

   // Opcodes 0110..1111 have no defined instruction.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_JMP);
   endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle processor main control FSM. Outputs are decoded from the state
// register and the opcode latched in DECODE; mem_ready gates FETCH/MEM_ACCESS,
// zero drives the branch PC write, and reset forces every strobe low at once.
module main_control_fsm
   import ctrl_pkg::*;
#(
   parameter int COUNT_W = 16
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         opcode,
   input  logic               mem_ready,
   input  logic               zero,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               pc_write,
   output logic               reg_write,
   output logic               alu_src,
   output logic               jump_sel,
   output logic [1:0]         alu_op,
   output logic [2:0]         state,
   output logic               illegal_op,
   output logic [COUNT_W-1:0] retired
);

   state_t             r_state;
   logic [3:0]         r_opcode;
   logic [COUNT_W-1:0] r_retired;
   logic               w_retire;

   // Cycles on which an instruction completes; SW completes out of MEM_ACCESS,
   // LW completes later in WRITEBACK.
   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         S_WRITEBACK, S_BRANCH, S_JUMP: w_retire = 1'b1;
         S_MEM_ACCESS:                  w_retire = mem_ready && (r_opcode == OP_SW);
         default:                       w_retire = 1'b0;
      endcase
   end

   // State transitions, opcode latch and retired-instruction counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_opcode  <= OP_RTYPE;
         r_retired <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (mem_ready) r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_opcode <= opcode;
               case (opcode)
                  OP_RTYPE, OP_LW, OP_SW, OP_ADDI: r_state <= S_EXECUTE;
                  OP_BEQ:                          r_state <= S_BRANCH;
                  OP_JMP:                          r_state <= S_JUMP;
                  default:                         r_state <= S_FETCH;
               endcase
            end
            S_EXECUTE: begin
               if ((r_opcode == OP_LW) || (r_opcode == OP_SW)) r_state <= S_MEM_ACCESS;
               else                                            r_state <= S_WRITEBACK;
            end
            S_MEM_ACCESS: begin
               if (mem_ready) r_state <= (r_opcode == OP_LW) ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK, S_BRANCH, S_JUMP: r_state <= S_FETCH;
            default:                       r_state <= S_FETCH;
         endcase
         if (w_retire) r_retired <= r_retired + COUNT_W'(1);
      end
   end

   // Control strobe decode; everything not named for the state stays low.
   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      jump_sel   = 1'b0;
      illegal_op = 1'b0;
      alu_op     = ALU_ADD;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               mem_read = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;
            end
            S_DECODE: begin
               illegal_op = !is_legal_op(opcode);
            end
            S_EXECUTE: begin
               if (r_opcode == OP_RTYPE) begin
                  alu_op = ALU_FUNC;
               end else if (r_opcode == OP_ADDI) begin
                  alu_op  = ALU_ADDI;
                  alu_src = 1'b1;
               end else begin
                  alu_op  = ALU_ADD;
                  alu_src = 1'b1;
               end
            end
            S_MEM_ACCESS: begin
               mem_read  = (r_opcode == OP_LW);
               mem_write = (r_opcode == OP_SW);
            end
            S_WRITEBACK: begin
               reg_write = 1'b1;
            end
            S_BRANCH: begin
               alu_op   = ALU_SUB;
               pc_write = zero;
            end
            S_JUMP: begin
               pc_write = 1'b1;
               jump_sel = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign state   = r_state;
   assign retired = r_retired;

endmodule
